// File: rtl/mem_ctrl_if.sv
// Client and RAM/IO bus signals of the memory controller.
// The master modport is the environment (fetch, LSB, RAM); the slave modport is mem_ctrl.
interface mem_ctrl_if #(
   parameter int LINE_BYTES = 64
);
   logic                      if_en;
   logic [31:0]               if_pc;
   logic [8*LINE_BYTES-1:0]   if_data;
   logic                      if_done;
   logic                      lsb_en;
   logic                      lsb_wr;
   logic [31:0]               lsb_addr;
   logic [1:0]                lsb_len;
   logic [31:0]               lsb_w_data;
   logic [31:0]               lsb_r_data;
   logic                      lsb_done;
   logic                      rollback;
   logic [7:0]                mem_din;
   logic [7:0]                mem_dout;
   logic [31:0]               mem_a;
   logic                      mem_wr;
   logic                      io_buffer_full;

   modport master (
      output if_en, if_pc, lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_w_data,
             rollback, mem_din, io_buffer_full,
      input  if_data, if_done, lsb_r_data, lsb_done, mem_dout, mem_a, mem_wr
   );

   modport slave (
      input  if_en, if_pc, lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_w_data,
             rollback, mem_din, io_buffer_full,
      output if_data, if_done, lsb_r_data, lsb_done, mem_dout, mem_a, mem_wr
   );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: I-cache line fills and LSB loads/stores over a byte RAM bus.
// Optional IO-store back-pressure is enabled by defining MEM_CTRL_IO_STALL_EN.
module mem_ctrl #(
   parameter int LINE_BYTES = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rdy,
   mem_ctrl_if.slave  bus
);
   localparam int CW = $clog2(LINE_BYTES + 1);
   localparam int LW = 8 * LINE_BYTES;

   typedef enum logic [2:0] {IDLE, IF_READ, LS_READ, LS_WRITE, COOL} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   nbytes;
   logic [31:0]     base;
   logic [31:0]     wdata;
   logic [LW-1:0]   line_buf;
   logic [LW-1:0]   buf_nxt;
   logic            ls_accept;
   logic            if_accept;
   logic            reading;
   logic            capture;
   logic            last_cap;
   logic            acc_stall;
   logic            io_stall;

   function automatic logic [CW-1:0] len_bytes(input logic [1:0] len);
      case (len)
         2'd0:    return CW'(1);
         2'd1:    return CW'(2);
         default: return CW'(4);
      endcase
   endfunction

   function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] sel);
      case (sel)
         2'd0:    return w[7:0];
         2'd1:    return w[15:8];
         2'd2:    return w[23:16];
         default: return w[31:24];
      endcase
   endfunction

   assign ls_accept = (state == IDLE) && bus.lsb_en && !bus.rollback;
   assign if_accept = (state == IDLE) && bus.if_en && !ls_accept;
   assign reading   = (state == IF_READ) || ((state == LS_READ) && !bus.rollback);
   // cnt counts edges since accept; byte cnt-1 arrives on mem_din one cycle behind mem_a
   assign capture   = reading && (cnt != '0);
   assign last_cap  = reading && (cnt == nbytes);

`ifdef MEM_CTRL_IO_STALL_EN
   assign acc_stall = (bus.lsb_addr[17:16] == 2'b11) && bus.io_buffer_full;
   assign io_stall  = (base[17:16] == 2'b11) && bus.io_buffer_full;
`else
   logic unused_io_full;
   assign unused_io_full = bus.io_buffer_full;
   assign acc_stall      = 1'b0;
   assign io_stall       = 1'b0;
`endif

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      buf_nxt = line_buf;
      for (int k = 0; k < LINE_BYTES; k++) begin
         if (cnt == CW'(k + 1)) buf_nxt[8*k +: 8] = bus.mem_din;
      end
   end

   // NOTE: the assembly buffer is pure datapath and is cleared at every accept, so it takes no reset.
   always_ff @(posedge clk) begin
      if (rdy) begin
         if (ls_accept || if_accept) line_buf <= '0;
         else if (capture)           line_buf <= buf_nxt;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= '0;
         nbytes         <= '0;
         base           <= '0;
         wdata          <= '0;
         bus.if_done    <= 1'b0;
         bus.lsb_done   <= 1'b0;
         bus.mem_wr     <= 1'b0;
         bus.mem_a      <= '0;
         bus.mem_dout   <= '0;
         bus.if_data    <= '0;
         bus.lsb_r_data <= '0;
      end else if (rdy) begin
         bus.if_done  <= 1'b0;
         bus.lsb_done <= 1'b0;
         unique case (state)
            IDLE: begin
               bus.mem_a  <= '0;
               bus.mem_wr <= 1'b0;
               cnt        <= '0;
               if (ls_accept) begin
                  base      <= bus.lsb_addr;
                  nbytes    <= len_bytes(bus.lsb_len);
                  wdata     <= bus.lsb_w_data;
                  bus.mem_a <= bus.lsb_addr;
                  if (!bus.lsb_wr) begin
                     state <= LS_READ;
                  end else begin
                     state <= LS_WRITE;
                     if (!acc_stall) begin
                        cnt          <= CW'(1);
                        bus.mem_wr   <= 1'b1;
                        bus.mem_dout <= bus.lsb_w_data[7:0];
                     end
                  end
               end else if (if_accept) begin
                  base      <= bus.if_pc;
                  nbytes    <= CW'(LINE_BYTES);
                  bus.mem_a <= bus.if_pc;
                  state     <= IF_READ;
               end
            end
            IF_READ, LS_READ: begin
               if ((state == LS_READ) && bus.rollback) begin
                  state     <= IDLE;
                  bus.mem_a <= '0;
               end else if (last_cap) begin
                  state     <= COOL;
                  bus.mem_a <= '0;
                  if (state == IF_READ) begin
                     bus.if_data <= buf_nxt;
                     bus.if_done <= 1'b1;
                  end else begin
                     bus.lsb_r_data <= buf_nxt[31:0];
                     bus.lsb_done   <= 1'b1;
                  end
               end else begin
                  cnt       <= cnt + CW'(1);
                  bus.mem_a <= base + 32'(cnt) + 32'd1;
               end
            end
            LS_WRITE: begin
               if (cnt == nbytes) begin
                  state        <= COOL;
                  bus.mem_wr   <= 1'b0;
                  bus.mem_a    <= '0;
                  bus.lsb_done <= 1'b1;
               end else if (io_stall) begin
                  bus.mem_wr <= 1'b0;
               end else begin
                  bus.mem_wr   <= 1'b1;
                  bus.mem_a    <= base + 32'(cnt);
                  bus.mem_dout <= byte_of(wdata, cnt[1:0]);
                  cnt          <= cnt + CW'(1);
               end
            end
            COOL:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed requests push expected events, a negedge monitor pops them.
// Also exercises MEM_CTRL_IO_STALL_EN when that macro is defined for the build.
module tb_mem_ctrl;
   logic clk = 1'b0;
   logic rst;
   logic rdy;
   int unsigned edge_n = 0;
   int total = 0;
   int bad = 0;

   mem_ctrl_if #(.LINE_BYTES(64)) bus ();

   mem_ctrl #(.LINE_BYTES(64)) dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   // RAM model: one-cycle read latency, paused by rdy like the controller
   logic [7:0] ram [0:4095];
   bit ram_ready = 1'b0;
   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < 4096; i++) ram[i] <= 8'(i);
         ram[12'h100] <= 8'h78;
         ram[12'h101] <= 8'h56;
         ram[12'h102] <= 8'h34;
         ram[12'h103] <= 8'h12;
         ram_ready    <= 1'b1;
      end else if (rdy) begin
         bus.mem_din <= ram[bus.mem_a[11:0]];
         if (bus.mem_wr) ram[bus.mem_a[11:0]] <= bus.mem_dout;
      end
   end

   typedef enum logic [1:0] {K_IF, K_LS, K_WR} kind_t;
   typedef struct {
      kind_t        kind;
      int unsigned  cyc;
      logic [511:0] data;
      logic [31:0]  addr;
      bit           chk;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic fail_event(input string name);
      total++;
      bad++;
      $display("FAIL %s: event missing or unexpected", name);
   endtask

   task automatic push(input kind_t k, input int unsigned cyc, input logic [511:0] d,
                       input logic [31:0] a, input bit chk);
      exp_t e;
      e.kind = k; e.cyc = cyc; e.data = d; e.addr = a; e.chk = chk;
      sb.push_back(e);
   endtask

   task automatic sb_pop(input kind_t k, input logic [511:0] d, input logic [31:0] a);
      exp_t e;
      if (sb.size() == 0) begin
         fail_event({"unexpected_", k.name()});
         return;
      end
      e = sb.pop_front();
      check({"kind_", e.kind.name()}, 512'(k), 512'(e.kind));
      check({"cycle_", k.name()}, 512'(edge_n), 512'(e.cyc));
      if (e.chk) check({"data_", k.name()}, d, e.data);
      if (k == K_WR) check("wr_addr", 512'(a), 512'(e.addr));
   endtask

   always @(negedge clk) begin
      if (!rst && rdy) begin
         if (bus.if_done)  sb_pop(K_IF, bus.if_data, 32'd0);
         if (bus.lsb_done) sb_pop(K_LS, 512'(bus.lsb_r_data), 32'd0);
         if (bus.mem_wr)   sb_pop(K_WR, 512'(bus.mem_dout), bus.mem_a);
      end
   end

   function automatic logic [511:0] line_of(input logic [7:0] start);
      logic [511:0] l;
      for (int k = 0; k < 64; k++) l[8*k +: 8] = start + 8'(k);
      return l;
   endfunction

   task automatic issue_ls(input bit wr, input logic [31:0] addr, input logic [1:0] len,
                           input logic [31:0] wd, output int unsigned acc);
      @(negedge clk);
      bus.lsb_en = 1'b1; bus.lsb_wr = wr; bus.lsb_addr = addr;
      bus.lsb_len = len; bus.lsb_w_data = wd;
      acc = edge_n + 1;
   endtask

   task automatic issue_if(input logic [31:0] pc, output int unsigned acc);
      @(negedge clk);
      bus.if_en = 1'b1; bus.if_pc = pc;
      acc = edge_n + 1;
   endtask

   // Waits for the done pulse, holds the enable `hold` extra cycles, then drops it
   task automatic wait_done(input bit is_if, input int hold, input int budget);
      int n = 0;
      bit seen = 1'b0;
      while (!seen && n < budget) begin
         @(negedge clk);
         n++;
         seen = is_if ? bus.if_done : bus.lsb_done;
      end
      if (!seen) fail_event(is_if ? "timeout_if_done" : "timeout_lsb_done");
      repeat (hold) @(negedge clk);
      if (is_if) bus.if_en = 1'b0;
      else       bus.lsb_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned a;
      int n;
      bit ls_seen, if_seen;

      rst = 1'b1; rdy = 1'b1;
      bus.if_en = 1'b0; bus.if_pc = '0; bus.lsb_en = 1'b0; bus.lsb_wr = 1'b0;
      bus.lsb_addr = '0; bus.lsb_len = '0; bus.lsb_w_data = '0;
      bus.rollback = 1'b0; bus.io_buffer_full = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_if_done", 512'(bus.if_done), 512'(0));
      check("rst_lsb_done", 512'(bus.lsb_done), 512'(0));
      check("rst_mem_wr", 512'(bus.mem_wr), 512'(0));
      check("rst_mem_a", 512'(bus.mem_a), 512'(0));
      check("rst_mem_dout", 512'(bus.mem_dout), 512'(0));
      check("rst_if_data", bus.if_data, 512'(0));
      check("rst_lsb_r_data", 512'(bus.lsb_r_data), 512'(0));
      rst = 1'b0;

      // Line fill at 0x40; if_en stays high through COOL and must not be re-accepted
      issue_if(32'h40, a);
      push(K_IF, a + 65, line_of(8'h40), 32'd0, 1'b1);
      wait_done(1'b1, 1, 200);
      check("fill_byte0", 512'(bus.if_data[7:0]), 512'(8'h40));
      check("fill_byte63", 512'(bus.if_data[511:504]), 512'(8'h7F));
      check("cool_mem_a", 512'(bus.mem_a), 512'(0));
      repeat (4) @(negedge clk);

      // Word load, then byte load
      issue_ls(1'b0, 32'h100, 2'd2, 32'd0, a);
      push(K_LS, a + 5, 512'(32'h1234_5678), 32'd0, 1'b1);
      wait_done(1'b0, 0, 20);
      issue_ls(1'b0, 32'h103, 2'd0, 32'd0, a);
      push(K_LS, a + 2, 512'(32'h12), 32'd0, 1'b1);
      wait_done(1'b0, 0, 20);

      // Half store of 0xBEEF to 0x200, then read it back two ways
      issue_ls(1'b1, 32'h200, 2'd1, 32'hDEAD_BEEF, a);
      push(K_WR, a, 512'(8'hEF), 32'h200, 1'b1);
      push(K_WR, a + 1, 512'(8'hBE), 32'h201, 1'b1);
      push(K_LS, a + 2, 512'(0), 32'd0, 1'b0);
      wait_done(1'b0, 0, 20);
      issue_ls(1'b0, 32'h201, 2'd0, 32'd0, a);
      push(K_LS, a + 2, 512'(32'hBE), 32'd0, 1'b1);
      wait_done(1'b0, 0, 20);
      issue_ls(1'b0, 32'h200, 2'd1, 32'd0, a);
      push(K_LS, a + 3, 512'(32'hBEEF), 32'd0, 1'b1);
      wait_done(1'b0, 0, 20);

      // Illegal length 3 behaves as a word
      issue_ls(1'b0, 32'h100, 2'd3, 32'd0, a);
      push(K_LS, a + 5, 512'(32'h1234_5678), 32'd0, 1'b1);
      wait_done(1'b0, 0, 20);

      // Simultaneous requests: LSB first, fill accepted at the edge after COOL
      @(negedge clk);
      bus.lsb_en = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_addr = 32'h100; bus.lsb_len = 2'd2;
      bus.if_en = 1'b1; bus.if_pc = 32'hC0;
      a = edge_n + 1;
      push(K_LS, a + 5, 512'(32'h1234_5678), 32'd0, 1'b1);
      push(K_IF, a + 7 + 65, line_of(8'hC0), 32'd0, 1'b1);
      n = 0; ls_seen = 1'b0; if_seen = 1'b0;
      while (!if_seen && n < 300) begin
         @(negedge clk);
         n++;
         if (bus.lsb_done) begin bus.lsb_en = 1'b0; ls_seen = 1'b1; end
         if (bus.if_done)  begin bus.if_en = 1'b0; if_seen = 1'b1; end
      end
      if (!ls_seen || !if_seen) fail_event("timeout_simultaneous");

      // Rollback at edge 2 of a word load: aborted, no done, IDLE next edge
      issue_ls(1'b0, 32'h100, 2'd2, 32'd0, a);
      @(negedge clk);
      @(negedge clk);
      check("rb_mem_a_inflight", 512'(bus.mem_a), 512'(32'h101));
      bus.rollback = 1'b1; bus.lsb_en = 1'b0;
      @(negedge clk);
      bus.rollback = 1'b0;
      check("rb_mem_a_idle", 512'(bus.mem_a), 512'(0));
      repeat (6) @(negedge clk);
      issue_ls(1'b0, 32'h102, 2'd0, 32'd0, a);
      push(K_LS, a + 2, 512'(32'h34), 32'd0, 1'b1);
      wait_done(1'b0, 0, 20);

      // Rollback during a fill does not disturb it
      issue_if(32'h80, a);
      push(K_IF, a + 65, line_of(8'h80), 32'd0, 1'b1);
      fork
         wait_done(1'b1, 0, 200);
         begin
            repeat (10) @(negedge clk);
            bus.rollback = 1'b1;
            @(negedge clk);
            bus.rollback = 1'b0;
         end
      join

      // rdy low for three edges delays a word load by three cycles
      issue_ls(1'b0, 32'h100, 2'd2, 32'd0, a);
      push(K_LS, a + 8, 512'(32'h1234_5678), 32'd0, 1'b1);
      @(negedge clk);
      rdy = 1'b0;
      repeat (3) @(negedge clk);
      rdy = 1'b1;
      wait_done(1'b0, 0, 20);

      // Reset mid-load abandons it silently
      issue_ls(1'b0, 32'h100, 2'd2, 32'd0, a);
      repeat (2) @(negedge clk);
      rst = 1'b1; bus.lsb_en = 1'b0;
      @(negedge clk);
      check("rst_mid_mem_a", 512'(bus.mem_a), 512'(0));
      check("rst_mid_lsb_done", 512'(bus.lsb_done), 512'(0));
      rst = 1'b0;
      repeat (8) @(negedge clk);

      // IO-region byte store with io_buffer_full high for three cycles
      bus.io_buffer_full = 1'b1;
      issue_ls(1'b1, 32'h3_0000, 2'd0, 32'h0000_005A, a);
`ifdef MEM_CTRL_IO_STALL_EN
      push(K_WR, a + 3, 512'(8'h5A), 32'h3_0000, 1'b1);
      push(K_LS, a + 4, 512'(0), 32'd0, 1'b0);
      repeat (3) @(negedge clk);
      bus.io_buffer_full = 1'b0;
      wait_done(1'b0, 0, 20);
`else
      push(K_WR, a, 512'(8'h5A), 32'h3_0000, 1'b1);
      push(K_LS, a + 1, 512'(0), 32'd0, 1'b0);
      wait_done(1'b0, 0, 20);
      bus.io_buffer_full = 1'b0;
`endif

      repeat (10) @(negedge clk);
      check("sb_drained", 512'(sb.size()), 512'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
